// File: rtl/angle_f2q.sv
// Float-to-fixed angle converter for the CORDIC z-path: IEEE-754 single in,
// signed Q(31-FRAC_BITS).FRAC_BITS out, two-stage pipeline with backpressure.
module angle_f2q #(
    parameter int FRAC_BITS = 29
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_angle,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_angle,
    output logic        out_range,
    output logic        out_sat,
    output logic        out_nan
);

    localparam int DATA_W = 32;
    localparam int MAG_W  = DATA_W - 1;
    // floor(pi/2 * 2^30) scaled down; flooring twice equals flooring once
    localparam logic [MAG_W-1:0]  PI2     = MAG_W'(32'h6487ED51 >> (30 - FRAC_BITS));
    localparam logic [7:0]        EXP_SAT = 8'(157 - FRAC_BITS);
    localparam logic signed [9:0] SH_OFF  = 10'(FRAC_BITS - 150);

    function automatic logic [MAG_W-1:0] shift_mag(input logic [23:0] sig,
                                                   input logic signed [9:0] sh);
        logic [MAG_W-1:0] wide;
        logic [9:0]       rsh;
        wide = {{(MAG_W-24){1'b0}}, sig};
        rsh  = 10'(-sh);
        // left shifts never exceed 7 once oversize exponents are saturated
        if (sh >= 10'sd0)
            return wide << sh[2:0];
        else if (sh > -10'sd24)
            return wide >> rsh[4:0];
        else
            return '0;
    endfunction

    function automatic logic signed [DATA_W-1:0] apply_sign(input logic sign,
                                                            input logic [MAG_W-1:0] mag);
        logic signed [DATA_W-1:0] pos;
        pos = signed'({1'b0, mag});
        return sign ? -pos : pos;
    endfunction

    logic                     en;
    logic [7:0]               exp_in;
    logic [22:0]              man_in;
    logic signed [9:0]        sh;
    logic                     is_nan;
    logic                     is_sat;
    logic [MAG_W-1:0]         mag_d;

    logic                     vld_p1;
    logic                     sign_p1;
    logic                     sat_p1;
    logic                     nan_p1;
    logic [MAG_W-1:0]         mag_p1;

    logic                     vld_p2;
    logic signed [DATA_W-1:0] angle_p2;
    logic                     range_p2;
    logic                     sat_p2;
    logic                     nan_p2;

    assign en       = !vld_p2 || out_ready;
    assign in_ready = en;

    always_comb begin
        exp_in = in_angle[30:23];
        man_in = in_angle[22:0];
        sh     = signed'({2'b00, exp_in}) + SH_OFF;
        is_nan = (exp_in == 8'hFF) && (man_in != 23'd0);
        is_sat = (exp_in > EXP_SAT) && !is_nan;
        mag_d  = shift_mag({1'b1, man_in}, sh);
        if (is_nan || exp_in == 8'd0)
            mag_d = '0;
        else if (is_sat)
            mag_d = '1;
    end

    // Stage 1: decoded sign, class and shifted magnitude
    always_ff @(posedge clk) begin
        if (en) begin
            sign_p1 <= in_angle[31];
            sat_p1  <= is_sat;
            nan_p1  <= is_nan;
            mag_p1  <= mag_d;
        end
    end

    // Stage 2: signed result, range compare and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            angle_p2 <= '0;
            range_p2 <= 1'b0;
            sat_p2   <= 1'b0;
            nan_p2   <= 1'b0;
        end else if (en) begin
            vld_p1   <= in_valid;
            vld_p2   <= vld_p1;
            angle_p2 <= apply_sign(sign_p1, mag_p1);
            range_p2 <= !nan_p1 && (mag_p1 > PI2);
            sat_p2   <= sat_p1;
            nan_p2   <= nan_p1;
        end
    end

    assign out_valid = vld_p2;
    assign out_angle = angle_p2;
    assign out_range = range_p2;
    assign out_sat   = sat_p2;
    assign out_nan   = nan_p2;

endmodule

// File: tb/tb_angle_f2q.sv
// Directed bench for angle_f2q at FRAC_BITS=29: streaming vectors, backpressure
// and reset-during-stall, all against hand-computed expected values.
module tb_angle_f2q;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_angle;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_angle;
    logic        out_range;
    logic        out_sat;
    logic        out_nan;

    int n_checks = 0;
    int n_pass   = 0;

    angle_f2q #(.FRAC_BITS(29)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
        .out_valid(out_valid), .out_ready(out_ready), .out_angle(out_angle),
        .out_range(out_range), .out_sat(out_sat), .out_nan(out_nan)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] flags();
        return {29'd0, out_range, out_sat, out_nan};
    endfunction

    // Stream vectors: input, expected angle, expected {range,sat,nan}
    localparam int NV = 16;
    logic [31:0] v_in  [NV] = '{
        32'h3F800000, 32'hBF800000, 32'h40000000, 32'h3C700000,
        32'h00000001, 32'h80000000, 32'h40800000, 32'hFF800000,
        32'h7FC00000, 32'h3FC90FDC, 32'hBFC90FDC, 32'h3FC90FDA,
        32'h30800000, 32'h31000000, 32'h407FFFFF, 32'hC0800000};
    logic [31:0] v_exp [NV] = '{
        32'h20000000, 32'hE0000000, 32'h40000000, 32'h00780000,
        32'h00000000, 32'h00000000, 32'h7FFFFFFF, 32'h80000001,
        32'h00000000, 32'h3243F700, 32'hCDBC0900, 32'h3243F680,
        32'h00000000, 32'h00000001, 32'h7FFFFF80, 32'h80000001};
    logic [2:0]  v_flg [NV] = '{
        3'b000, 3'b000, 3'b100, 3'b000,
        3'b000, 3'b000, 3'b110, 3'b110,
        3'b001, 3'b100, 3'b100, 3'b000,
        3'b000, 3'b000, 3'b100, 3'b110};

    logic [31:0] bp_in  [4] = '{32'h3F800000, 32'hBF800000, 32'h3C700000, 32'hFF800000};
    logic [31:0] bp_exp [4] = '{32'h20000000, 32'hE0000000, 32'h00780000, 32'h80000001};

    initial begin
        int sent;
        int got;
        bit took_in;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_angle  = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_angle", out_angle, 32'd0);
        check("rst_flags", flags(), 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // Back-to-back stream; result for vector i is seen two cycles after it
        for (int j = 0; j < NV + 2; j++) begin
            @(negedge clk);
            if (j < 2) begin
                check($sformatf("lat_valid%0d", j), {31'd0, out_valid}, 32'd0);
            end else begin
                check($sformatf("v%0d_valid", j-2), {31'd0, out_valid}, 32'd1);
                check($sformatf("v%0d_angle", j-2), out_angle, v_exp[j-2]);
                check($sformatf("v%0d_flags", j-2), flags(), {29'd0, v_flg[j-2]});
            end
            if (j < NV) begin
                in_valid = 1'b1;
                in_angle = v_in[j];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: out_ready low for the first 5 cycles
        sent = 0;
        got  = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            out_ready = (c >= 5);
            in_valid  = (sent < 4);
            in_angle  = (sent < 4) ? bp_in[sent] : 32'd0;
            #1;
            if (c >= 2 && c <= 4) begin
                check($sformatf("bp_in_ready_c%0d", c), {31'd0, in_ready}, 32'd0);
                check($sformatf("bp_hold_c%0d", c), out_angle, bp_exp[0]);
                check($sformatf("bp_hold_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp_out%0d", got), out_angle, bp_exp[got]);
                got++;
            end
            took_in = in_valid && in_ready;
            @(posedge clk);
            if (took_in) sent++;
            @(negedge clk);
        end
        check("bp_all_results", got, 32'd4);
        in_valid = 1'b0;

        // Reset while stalled with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_angle  = 32'h40000000;
        @(negedge clk);
        in_angle  = 32'h3F800000;
        @(negedge clk);
        in_valid = 1'b0;
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_angle", out_angle, 32'h40000000);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_stall_valid", {31'd0, out_valid}, 32'd0);
        check("rst_stall_angle", out_angle, 32'd0);
        check("rst_stall_flags", flags(), 32'd0);
        check("rst_stall_in_ready", {31'd0, in_ready}, 32'd1);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_no_ghost", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("post_rst_no_ghost2", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/angle_f2q.md
# angle_f2q

Pipelined converter from an IEEE-754 single-precision angle in radians to the signed fixed-point angle that drives the CORDIC z-path. It sits alongside the float angle comparator (`angle_greater`), on the same float input, and feeds the CORDIC iteration engine. The converter classifies special operands and saturates oversize inputs. It flags angles outside the CORDIC convergence range of |θ| > π/2 and carries a valid/ready handshake with backpressure.

## Interface
- `FRAC_BITS`, default 29: fractional bits of the output, signed Q(31-FRAC_BITS).FRAC_BITS in 32 bits; legal range 24..30.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_angle` is valid this cycle.
- `in_ready` output 1: the block accepts `in_angle` this cycle.
- `in_angle` input 32: IEEE-754 single: sign[31], exp[30:23], mant[22:0].
- `out_valid` output 1: the result registers hold a valid result.
- `out_ready` input 1: downstream accepts the result this cycle.
- `out_angle` output 32: signed two's-complement fixed-point angle.
- `out_range` output 1: |result| > π/2 (Q-threshold PI2 = floor(π/2·2^FRAC_BITS); 0x3243F6A8 at FRAC_BITS=29).
- `out_sat` output 1: input was ±Inf or |value| ≥ 2^(31-FRAC_BITS); output is saturated.
- `out_nan` output 1: input was NaN.

## Operation
- Decode: e = exp, m = mant. Significand sig = {1,m} is 24 bits. Shift sh = e − 150 + FRAC_BITS.
- e = 255, m ≠ 0 (NaN) → magnitude 0, `out_nan`=1, `out_range`=0, `out_sat`=0.
- e = 255, m = 0 (Inf) → magnitude 0x7FFFFFFF, `out_sat`=1, `out_range`=1.
- e = 0 (±zero or denormal) → magnitude 0; flush to zero; no flags.
- e > 157 − FRAC_BITS → magnitude 0x7FFFFFFF, `out_sat`=1, `out_range`=1.
- sh ≥ 0 → magnitude = sig << sh. The result fits in 31 bits by construction.
- −24 < sh < 0 → magnitude = sig >> −sh. This truncates toward zero; there is no rounding.
- sh ≤ −24 → magnitude 0.
- Sign: `out_angle` = sign ? −magnitude : magnitude.
  - Saturation is symmetric: the negative saturated value is 0x80000001, never 0x80000000.
  - −0.0 gives 0x00000000.
- `out_range` = (magnitude > PI2) for every non-NaN input. Equality to PI2 gives 0.
- At most one of `out_nan` and `out_sat` is set for any result.

## Timing
- Two register stages:
  - S1 holds the decoded sign, class, and shifted magnitude.
  - S2 holds the negation, the range compare, and the output registers.
- Latency is 2 cycles from accept to `out_valid`. Throughput is 1 result per cycle.
- Advance enable: en = !`out_valid` || `out_ready`. Both stages shift only when en=1, and the whole pipe stalls as a unit.
- `in_ready` = en. It depends combinationally on `out_ready`, with no other combinational path from input to output.
- Accept occurs when `in_valid` && `in_ready`. S1 valid then loads `in_valid` on en.
- While `out_valid`=1 and `out_ready`=0, `out_angle` and the flags hold stable.
- A bubble in S1 propagates as `out_valid`=0. A result in S2 is never dropped or duplicated.
- Simultaneous consume and new result: with `out_ready`=1 and S1 valid, S2 reloads in the same edge and `out_valid` stays 1.
- Reset, any cycle including mid-stall: on the next edge all valids, `out_valid`, `out_angle`, `out_range`, `out_sat`, and `out_nan` become 0. In-flight data is discarded.
- After reset, `in_ready`=1.

## Test plan
- 0x3F800000 (1.0) → 2 cycles later `out_angle`=0x20000000; all flags 0.
- 0xBF800000 (−1.0) → 0xE0000000, then 0x40000000 (2.0) → 0x40000000 with `out_range`=1.
  - These are back-to-back inputs, so the results must be on consecutive cycles.
- 0x3C700000 (0.0146484375) → 0x00780000.
- 0x00000001 (denormal) and 0x80000000 (−0.0) → 0x00000000 with no flags.
- 0x40800000 (4.0) → 0x7FFFFFFF with `out_sat`=1 and `out_range`=1.
  - 0xFF800000 (−Inf) → 0x80000001 with `out_sat`=1.
  - 0x7FC00000 (NaN) → 0x00000000 with `out_nan`=1.
- Backpressure: stream 4 inputs while `out_ready` is held 0 for 5 cycles.
  - `in_ready` must drop once the pipe is full and `out_angle` must hold.
  - After release, all 4 results arrive in order.
  - Asserting `rst` during a later stall clears `out_valid` on the next edge.
